// File: rtl/result_drain_ctrl.sv
// Result SRAM drain controller: reads a programmed range of result words and
// streams them out one partial sum per valid/ready beat, lane 0 first.
module result_drain_ctrl #(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int MATRIX_SIZE    = 8,
    parameter int COUNT_BW       = 10
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    input  logic [COUNT_BW-1:0]                   num_words,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  sram_read_enable,
    output logic [ADDRESSSIZE-1:0]                sram_address,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_data_out,
    output logic [PARTIAL_SUM_BW-1:0]             out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last,
    output logic [COUNT_BW-1:0]                   out_word_idx,
    output logic [$clog2(MATRIX_SIZE)-1:0]        out_elem_idx
);

    localparam int ELEM_BW = $clog2(MATRIX_SIZE);
    localparam int WORD_BW = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam logic [ELEM_BW-1:0] LAST_LANE = ELEM_BW'(MATRIX_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAPT,
        S_SEND,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [ADDRESSSIZE-1:0] r_base;
    logic [COUNT_BW-1:0]    r_num;
    logic [COUNT_BW-1:0]    r_word_idx;
    logic [ELEM_BW-1:0]     r_elem_idx;
    logic [WORD_BW-1:0]     r_word;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_rd_en;
    logic [ADDRESSSIZE-1:0] r_rd_addr;
    logic                   r_out_valid;

    logic [COUNT_BW-1:0]    w_next_word_idx;
    logic [ADDRESSSIZE-1:0] w_next_addr;
    logic                   w_lane_last;
    logic                   w_word_last;
    logic                   w_beat;

    // Word index never exceeds num_words-1, so the +1 below cannot overflow.
    assign w_next_word_idx = r_word_idx + COUNT_BW'(1);
    assign w_next_addr     = r_base + ADDRESSSIZE'(w_next_word_idx);
    assign w_lane_last     = (r_elem_idx == LAST_LANE);
    assign w_word_last     = (w_next_word_idx == r_num);
    assign w_beat          = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_num       <= '0;
            r_word_idx  <= '0;
            r_elem_idx  <= '0;
            // NOTE: the word register is cleared too so out_data reads 0 after reset;
            // the SRAM itself is never touched by this reset.
            r_word      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base     <= base_addr;
                        r_num      <= num_words;
                        r_word_idx <= '0;
                        r_elem_idx <= '0;
                        r_busy     <= 1'b1;
                        if (num_words != '0) begin
                            r_state   <= S_REQ;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= base_addr;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    r_rd_en   <= 1'b0;
                    r_rd_addr <= '0;
                    r_state   <= S_CAPT;
                end
                S_CAPT: begin
                    r_word      <= sram_data_out;
                    r_elem_idx  <= '0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (w_beat) begin
                        if (!w_lane_last) begin
                            r_elem_idx <= r_elem_idx + ELEM_BW'(1);
                        end else if (!w_word_last) begin
                            r_word_idx  <= w_next_word_idx;
                            r_out_valid <= 1'b0;
                            r_rd_en     <= 1'b1;
                            r_rd_addr   <= w_next_addr;
                            r_state     <= S_REQ;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign sram_read_enable = r_rd_en;
    assign sram_address     = r_rd_addr;
    assign out_valid        = r_out_valid;
    assign out_data         = r_word[int'(r_elem_idx) * PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
    assign out_last         = r_out_valid && w_lane_last && w_word_last;
    assign out_word_idx     = r_word_idx;
    assign out_elem_idx     = r_elem_idx;

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Self-checking bench for result_drain_ctrl: SRAM model, beat-queue reference
// model, per-cycle stream compare and directed plus randomized drains.
module tb_result_drain_ctrl;

    localparam int AW = 10;
    localparam int PW = 20;
    localparam int MS = 8;
    localparam int CW = 10;
    localparam int WW = PW * MS;

    typedef struct {
        logic [PW-1:0] data;
        logic          last;
        logic [CW-1:0] widx;
        logic [2:0]    eidx;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_words = '0;
    logic          busy, done, sram_read_enable, out_valid, out_last;
    logic          out_ready = 1'b1;
    logic [AW-1:0] sram_address;
    logic [WW-1:0] sram_data_out = '0;
    logic [PW-1:0] out_data;
    logic [CW-1:0] out_word_idx;
    logic [2:0]    out_elem_idx;

    logic [WW-1:0] mem [1024];
    beat_t         exp_q [$];
    int            addr_q [$];
    logic [PW-1:0] got_q [$];
    int            rd_log [$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_done = 0;
    int            mode = 0;
    int            phase = 0;
    logic          prev_stall = 1'b0;

    result_drain_ctrl #(
        .ADDRESSSIZE(AW), .PARTIAL_SUM_BW(PW), .MATRIX_SIZE(MS), .COUNT_BW(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done),
        .sram_read_enable(sram_read_enable), .sram_address(sram_address),
        .sram_data_out(sram_data_out), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_word_idx(out_word_idx),
        .out_elem_idx(out_elem_idx)
    );

    always #5 clk = ~clk;

    // Result SRAM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (sram_read_enable) sram_data_out <= mem[sram_address];
    end

    // Sink: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
    always @(posedge clk) begin
        #1;
        case (mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (phase % 4 == 0) || (phase % 4 == 3); phase++; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        beat_t b;
        if (rstn) begin
            if (done) n_done++;
            if (sram_read_enable) begin
                rd_log.push_back(int'(sram_address));
                if (addr_q.size() == 0) check("unexpected_read", 1, 0);
                else check("read_addr", sram_address, addr_q.pop_front());
            end else begin
                check("idle_addr_zero", sram_address, 0);
            end
            if (prev_stall) check("valid_held_in_stall", out_valid, 1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    b = exp_q[0];
                    check("out_data", out_data, b.data);
                    check("out_last", out_last, b.last);
                    check("out_word_idx", out_word_idx, b.widx);
                    check("out_elem_idx", out_elem_idx, b.eidx);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got_q.push_back(out_data);
                    end
                end
            end else begin
                check("last_low_without_valid", out_last, 0);
            end
            prev_stall = out_valid && !out_ready;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference model: the expected read addresses and beat stream of a drain.
    task automatic build_model(input int base, input int num);
        for (int w = 0; w < num; w++) begin
            int a;
            a = (base + w) % 1024;
            addr_q.push_back(a);
            for (int k = 0; k < MS; k++) begin
                beat_t b;
                b.data = mem[a][k*PW +: PW];
                b.last = (w == num - 1) && (k == MS - 1);
                b.widx = CW'(w);
                b.eidx = 3'(k);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic start_drain(input int base, input int num);
        got_q.delete();
        rd_log.delete();
        build_model(base, num);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = AW'(base);
        num_words = CW'(num);
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = AW'($urandom);
        num_words = CW'($urandom);
        check("busy_cycle1", busy, 1);
    endtask

    // Waits for done; exp_cycles counts from the start cycle (cycle 0), -1 = any.
    task automatic wait_done(input int exp_cycles);
        int k;
        k = 1;
        while (!done && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) begin
            check("done_timeout", 0, 1);
            return;
        end
        if (exp_cycles >= 0) check("done_latency", k, exp_cycles);
        check("beats_left_at_done", exp_q.size(), 0);
        check("reads_left_at_done", addr_q.size(), 0);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("busy_low_after_done", busy, 0);
    endtask

    task automatic set_mode(input int m);
        mode = m;
        phase = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=1 exp=0");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < MS; k++) mem[w][k*PW +: PW] = PW'(w * 16 + k);
        mem[10][3*PW +: PW] = 20'hFFFFB;
        mem[10][7*PW +: PW] = 20'h80000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_rd_en", sram_read_enable, 0);
        check("rst_addr", sram_address, 0);
        check("rst_last", out_last, 0);
        check("rst_widx", out_word_idx, 0);
        check("rst_eidx", out_elem_idx, 0);
        check("rst_data", out_data, 0);
        rstn = 1'b1;

        // Basic drain, sink always ready.
        set_mode(0);
        start_drain(0, 3);
        wait_done(31);
        check("basic_count", got_q.size(), 24);
        check("basic_first", got_q[0], 0);
        check("basic_word1_lane0", got_q[8], 16);
        check("basic_final", got_q[23], 39);

        // Backpressure 1,0,0,1.
        set_mode(1);
        start_drain(0, 3);
        wait_done(-1);
        check("bp_count", got_q.size(), 24);
        check("bp_word1_lane7", got_q[15], 23);

        // Negative values and full-width bits.
        set_mode(0);
        start_drain(10, 1);
        wait_done(11);
        check("neg_lane3", got_q[3], 20'hFFFFB);
        check("neg_lane7", got_q[7], 20'h80000);

        // Address wrap and zero-length drain.
        start_drain(1023, 2);
        wait_done(21);
        check("wrap_first_addr", rd_log[0], 1023);
        check("wrap_second_addr", rd_log[1], 0);
        start_drain(7, 0);
        wait_done(1);
        check("zero_no_beats", got_q.size(), 0);

        // Start while busy is ignored.
        n0 = n_done;
        start_drain(40, 2);
        repeat (8) @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 5;
        num_words = 7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(-1);
        repeat (3) @(posedge clk);
        #1;
        check("single_done", n_done - n0, 1);
        check("busy_start_beats", got_q.size(), 16);

        // Reset during word 1.
        start_drain(100, 3);
        for (int i = 0; i < 100 && !(out_valid && out_word_idx == 1); i++) begin
            @(posedge clk); #1;
        end
        check("reached_word1", out_valid && out_word_idx == 1, 1);
        rstn = 1'b0;
        exp_q.delete();
        addr_q.delete();
        n0 = n_done;
        @(posedge clk); #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_done", n_done - n0, 0);
        start_drain(200, 2);
        wait_done(21);

        // Randomized drains.
        for (int t = 0; t < 20; t++) begin
            int m, b, n;
            m = $urandom_range(0, 2);
            b = $urandom_range(0, 1023);
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
            set_mode(m);
            start_drain(b, n);
            if (n == 0) wait_done(1);
            else wait_done(m == 0 ? n * (MS + 2) + 1 : -1);
            check("rand_beat_count", got_q.size(), n * MS);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
